// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared mode encodings and per-stage move helper for the barrel shifter
package shifter_pkg;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SLL = 2'b10;
    localparam logic [1:0] MODE_SRL = 2'b11;

    // Widest data path the helper supports; narrower widths use the low bits.
    localparam int MAX_W = 64;

    // Move the low w bits of d by sh positions; rotates wrap, shifts zero-fill.
    function automatic logic [MAX_W-1:0] stage_move(
        input logic [MAX_W-1:0] d,
        input int               w,
        input int               sh,
        input logic [1:0]       mode
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] dm;
        logic [MAX_W-1:0] r;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        dm   = d & mask;
        r    = dm;
        case (mode)
            MODE_ROL: r = (dm << sh) | (dm >> (w - sh));
            MODE_ROR: r = (dm >> sh) | (dm << (w - sh));
            MODE_SLL: r = dm << sh;
            MODE_SRL: r = dm >> sh;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/barrel_stage.sv
// rtl/barrel_stage.sv - one 2^K move of the barrel shifter plus its pipeline register
module barrel_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH),
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_advance,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    input  logic [SHW-1:0]   i_amt,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_mode,
    output logic [SHW-1:0]   o_amt,
    output logic             o_zero_next
);

    // Amount bits at or below K are consumed here; only the higher bits travel on.
    localparam logic [SHW-1:0] AMT_KEEP = {SHW{1'b1}} << (K + 1);

    logic [WIDTH-1:0] w_moved;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_mode;
    logic [SHW-1:0]   r_amt;

    assign w_moved     = i_amt[K] ? WIDTH'(stage_move(MAX_W'(i_data), WIDTH, 1 << K, i_mode))
                                  : i_data;
    assign o_zero_next = (w_moved == '0);

    // Stage register: loads on advance, otherwise holds (global stall).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_mode  <= '0;
            r_amt   <= '0;
        end else if (i_advance) begin
            r_valid <= i_valid;
            r_data  <= w_moved;
            r_mode  <= i_mode;
            r_amt   <= i_amt & AMT_KEEP;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_mode  = r_mode;
    assign o_amt   = r_amt;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined rotate/shift unit with valid/ready handshakes
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    logic             w_valid     [0:SHW];
    logic [WIDTH-1:0] w_data      [0:SHW];
    logic [1:0]       w_mode      [0:SHW];
    logic [SHW-1:0]   w_amt       [0:SHW];
    logic             w_zero_next [0:SHW-1];
    logic             w_advance;
    logic             r_out_zero;

    // Whole pipeline moves together whenever the result slot is empty or being taken.
    assign w_advance = !w_valid[SHW] || out_ready;
    assign in_ready  = w_advance;

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_mode[0]  = in_mode;
    assign w_amt[0]   = in_amt;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .K     (k)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .i_advance   (w_advance),
            .i_valid     (w_valid[k]),
            .i_data      (w_data[k]),
            .i_mode      (w_mode[k]),
            .i_amt       (w_amt[k]),
            .o_valid     (w_valid[k+1]),
            .o_data      (w_data[k+1]),
            .o_mode      (w_mode[k+1]),
            .o_amt       (w_amt[k+1]),
            .o_zero_next (w_zero_next[k])
        );
    end

    // Zero flag registered alongside the final stage, forced low for bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_zero <= 1'b0;
        end else if (w_advance) begin
            r_out_zero <= w_zero_next[SHW-1] && w_valid[SHW-1];
        end
    end

    assign out_valid = w_valid[SHW];
    assign out_data  = w_data[SHW];
    assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - self-checking bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        v16, rdy16, ov16, or16, oz16;
    logic [15:0] d16, od16;
    logic [3:0]  a16;
    logic [1:0]  m16;

    logic        sv, sor;
    logic [31:0] sd;
    logic [4:0]  sa;
    logic [1:0]  sm;
    int          soak_w;
    logic        sv8, sv32;
    logic        rdy8, ov8, oz8, rdy32, ov32, oz32;
    logic [7:0]  od8;
    logic [31:0] od32;

    assign sv8  = sv && (soak_w == 8);
    assign sv32 = sv && (soak_w == 32);

    pipelined_barrel_shifter #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_data(d16),
        .in_amt(a16), .in_mode(m16), .out_valid(ov16), .out_ready(or16),
        .out_data(od16), .out_zero(oz16));

    pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(sv8), .in_ready(rdy8), .in_data(sd[7:0]),
        .in_amt(sa[2:0]), .in_mode(sm), .out_valid(ov8), .out_ready(sor),
        .out_data(od8), .out_zero(oz8));

    pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(sv32), .in_ready(rdy32), .in_data(sd),
        .in_amt(sa), .in_mode(sm), .out_valid(ov32), .out_ready(sor),
        .out_data(od32), .out_zero(oz32));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bit-index definition of each operation on a w-bit word.
    function automatic logic [31:0] ref_model(input logic [31:0] d, input int amt,
                                              input logic [1:0] m, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                2'b00: r[i] = d[(i - amt + w) % w];
                2'b01: r[i] = d[(i + amt) % w];
                2'b10: r[i] = (i >= amt) ? d[i - amt] : 1'b0;
                default: r[i] = (i + amt < w) ? d[i + amt] : 1'b0;
            endcase
        end
        return r;
    endfunction

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  amt;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [12];

    // Single transaction with out_ready high; lat counts edges from the accept edge (0 = timeout).
    task automatic run_one(input logic [1:0] m, input logic [3:0] a, input logic [15:0] d,
                           output logic [15:0] got, output logic gz, output int lat);
        @(negedge clk);
        m16 = m; a16 = a; d16 = d; v16 = 1'b1; or16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov16) lat = 0;
        got = od16;
        gz  = oz16;
        @(posedge clk); #1;
    endtask

    task automatic soak(input int w, input int n);
        logic [31:0] q[$];
        logic [31:0] exp_d, got_d, mask;
        logic        r_rdy, r_ov, r_oz;
        int          acc, cyc, errs_before;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        soak_w = w;
        acc = 0; cyc = 0;
        errs_before = bad;
        while ((acc < n || q.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            sv  = (acc < n) ? ($urandom_range(0, 3) != 0) : 1'b0;
            sd  = $urandom & mask;
            sa  = 5'($urandom_range(0, w - 1));
            sm  = 2'($urandom_range(0, 3));
            sor = ($urandom_range(0, 9) < 7);
            #1;
            if (w == 8) begin
                r_rdy = rdy8; r_ov = ov8; got_d = {24'd0, od8}; r_oz = oz8;
            end else begin
                r_rdy = rdy32; r_ov = ov32; got_d = od32; r_oz = oz32;
            end
            if (r_ov && sor) begin
                if (q.size() == 0) begin
                    chk($sformatf("soak%0d_extra_result", w), 1, 0);
                end else begin
                    exp_d = q.pop_front();
                    chk($sformatf("soak%0d_data", w), got_d, exp_d);
                    chk($sformatf("soak%0d_zero", w), r_oz, exp_d == 0);
                end
            end
            if (sv && r_rdy) begin
                q.push_back(ref_model(sd, int'(sa), sm, w));
                acc++;
            end
            cyc++;
        end
        sv = 1'b0;
        chk($sformatf("soak%0d_all_retired", w), q.size(), 0);
        chk($sformatf("soak%0d_accepted", w), acc, n);
        if (bad != errs_before) $display("soak width %0d saw errors", w);
    endtask

    logic [15:0] bp_exp [6];
    logic [15:0] got;
    logic        gz;
    int          lat;

    initial begin
        vecs[0]  = '{2'b00, 4'd1,  16'h8001, 16'h0003, 1'b0};
        vecs[1]  = '{2'b01, 4'd4,  16'h1234, 16'h4123, 1'b0};
        vecs[2]  = '{2'b00, 4'd15, 16'h0001, 16'h8000, 1'b0};
        vecs[3]  = '{2'b00, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0};
        vecs[4]  = '{2'b01, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0};
        vecs[5]  = '{2'b10, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0};
        vecs[6]  = '{2'b11, 4'd0,  16'hA5A5, 16'hA5A5, 1'b0};
        vecs[7]  = '{2'b10, 4'd15, 16'hFFFF, 16'h8000, 1'b0};
        vecs[8]  = '{2'b11, 4'd1,  16'h0001, 16'h0000, 1'b1};
        vecs[9]  = '{2'b01, 4'd15, 16'h0001, 16'h0002, 1'b0};
        vecs[10] = '{2'b11, 4'd4,  16'hF0F0, 16'h0F0F, 1'b0};
        vecs[11] = '{2'b10, 4'd4,  16'hF000, 16'h0000, 1'b1};

        bp_exp[0] = 16'h0002; bp_exp[1] = 16'h0008; bp_exp[2] = 16'h0018;
        bp_exp[3] = 16'h0040; bp_exp[4] = 16'h00A0; bp_exp[5] = 16'h0180;

        rst = 1'b1; v16 = 1'b0; or16 = 1'b0; d16 = '0; a16 = '0; m16 = '0;
        sv = 1'b0; sor = 1'b0; sd = '0; sa = '0; sm = '0; soak_w = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("reset_out_valid", ov16, 0);
        chk("reset_out_data", od16, 0);
        chk("reset_out_zero", oz16, 0);
        chk("reset_in_ready", rdy16, 1);

        for (int i = 0; i < 12; i++) begin
            run_one(vecs[i].mode, vecs[i].amt, vecs[i].data, got, gz, lat);
            chk($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
            chk($sformatf("vec%0d_zero", i), gz, vecs[i].exp_zero);
            chk($sformatf("vec%0d_latency", i), lat, 4);
        end

        // Backpressure: six back-to-back ROL transactions, out_ready low for three cycles.
        begin
            int          idx, ret, stall_prev;
            logic [15:0] hold;
            idx = 0; ret = 0; stall_prev = 0; hold = '0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                v16  = (idx < 6);
                d16  = 16'(idx + 1);
                a16  = 4'(idx + 1);
                m16  = 2'b00;
                or16 = !(c >= 5 && c <= 7);
                #1;
                chk($sformatf("bp_in_ready_c%0d", c), rdy16, !ov16 || or16);
                if (stall_prev != 0) begin
                    chk($sformatf("bp_hold_valid_c%0d", c), ov16, 1);
                    chk($sformatf("bp_hold_data_c%0d", c), od16, hold);
                end
                stall_prev = (ov16 && !or16) ? 1 : 0;
                hold = od16;
                if (ov16 && or16) begin
                    if (ret < 6) chk($sformatf("bp_result%0d", ret), od16, bp_exp[ret]);
                    else chk("bp_duplicate", 1, 0);
                    ret++;
                end
                if (v16 && rdy16) idx++;
            end
            v16 = 1'b0;
            chk("bp_accepted", idx, 6);
            chk("bp_retired", ret, 6);
        end

        // Reset with three transactions in flight.
        begin
            int stale;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                v16 = 1'b1; or16 = 1'b1; d16 = 16'h1111 * 16'(i + 1); a16 = 4'd3; m16 = 2'b00;
            end
            @(negedge clk);
            v16 = 1'b0; rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_mid_out_valid", ov16, 0);
            chk("rst_mid_in_ready", rdy16, 1);
            @(negedge clk); rst = 1'b0;
            stale = 0;
            repeat (8) begin
                @(posedge clk); #1;
                if (ov16) stale++;
            end
            chk("rst_mid_no_stale", stale, 0);
            run_one(2'b00, 4'd1, 16'h8001, got, gz, lat);
            chk("rst_after_data", got, 16'h0003);
            chk("rst_after_latency", lat, 4);
        end

        soak(8, 5000);
        soak(32, 5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
